// File: rtl/cfu_cmd_issuer_if.sv
// CFU command/response bus between the issuer (master) and a CFU (slave).
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface cfu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_cmd_issuer.sv
// Issues queued CFU commands one at a time and collects their results into a response queue.
// Errors (timeout in WAIT_RSP, response outside WAIT_RSP) are sticky until reset.
module cfu_cmd_issuer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [9:0]             push_function_id,
    input  logic [31:0]            push_in0,
    input  logic [31:0]            push_in1,
    cfu_cmd_issuer_if.master       cfu,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [31:0]            pop_data,
    output logic                   busy,
    output logic [15:0]            issued_count,
    output logic                   err_timeout,
    output logic                   err_spurious,
    output logic [1:0]             dbg_state
);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam int RW = $clog2(RSP_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;

    logic [1:0]    state;
    logic [73:0]   cmd_mem [CMD_DEPTH];
    logic [CW-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CW:0]   cmd_count;
    logic          cmd_full, cmd_empty, cmd_push, cmd_pop;

    logic [31:0]   rsp_mem [RSP_DEPTH];
    logic [RW-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [RW:0]   rsp_count;
    logic          rsp_empty, rsp_push, rsp_pop;

    logic          pending, credit_ok;
    logic [TW-1:0] wait_cnt;

    assign cmd_empty = (cmd_count == '0);
    assign cmd_full  = (cmd_count == (CW+1)'(CMD_DEPTH));
    assign rsp_empty = (rsp_count == '0);

    // An issued command reserves a response slot until its result lands.
    assign pending   = (state != S_IDLE);
    assign credit_ok = (rsp_count + (RW+1)'(pending)) < (RW+1)'(RSP_DEPTH);

    assign cmd_pop   = (state == S_IDLE) && !cmd_empty && credit_ok;
    // A full queue still takes a push on the edge it hands its head to the FSM.
    assign cmd_push  = push_valid && (!cmd_full || cmd_pop);
    assign rsp_push  = (state == S_WAIT_RSP) && cfu.rsp_ready && cfu.rsp_valid;
    assign rsp_pop   = !rsp_empty && pop_ready;

    assign push_ready = !cmd_full;
    assign pop_valid  = !rsp_empty;
    assign pop_data   = rsp_mem[rsp_rd_ptr];
    assign busy       = !cmd_empty || (state != S_IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= {push_function_id, push_in0, push_in1};
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= cfu.rsp_payload_outputs_0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            cmd_count <= cmd_count + (CW+1)'(cmd_push) - (CW+1)'(cmd_pop);
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            rsp_count <= rsp_count + (RW+1)'(rsp_push) - (RW+1)'(rsp_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                       <= S_IDLE;
            cfu.cmd_valid               <= 1'b0;
            cfu.rsp_ready               <= 1'b0;
            cfu.cmd_payload_function_id <= '0;
            cfu.cmd_payload_inputs_0    <= '0;
            cfu.cmd_payload_inputs_1    <= '0;
            issued_count                <= '0;
            wait_cnt                    <= '0;
            err_timeout                 <= 1'b0;
            err_spurious                <= 1'b0;
        end else begin
            if (cfu.rsp_valid && (state == S_IDLE || state == S_ISSUE)) err_spurious <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_pop) begin
                        {cfu.cmd_payload_function_id, cfu.cmd_payload_inputs_0,
                         cfu.cmd_payload_inputs_1} <= cmd_mem[cmd_rd_ptr];
                        cfu.cmd_valid <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cfu.cmd_ready) begin
                        cfu.cmd_valid <= 1'b0;
                        cfu.rsp_ready <= 1'b1;
                        issued_count  <= issued_count + 1'b1;
                        wait_cnt      <= '0;
                        state         <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (cfu.rsp_valid) begin
                        cfu.rsp_ready <= 1'b0;
                        state         <= S_IDLE;
                    end else if (wait_cnt != TW'(TIMEOUT)) begin
                        // Counter saturates; the FSM keeps waiting after flagging.
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == TW'(TIMEOUT - 1)) err_timeout <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Directed and randomized bench for cfu_cmd_issuer against a queue-based model and a CFU responder.
module tb_cfu_cmd_issuer;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2;

    logic        clk, reset_n;
    logic        push_valid, push_ready;
    logic [9:0]  push_function_id;
    logic [31:0] push_in0, push_in1;
    logic        pop_valid, pop_ready;
    logic [31:0] pop_data;
    logic        busy, err_timeout, err_spurious;
    logic [15:0] issued_count;
    logic [1:0]  dbg_state;

    cfu_cmd_issuer_if cfu ();

    cfu_cmd_issuer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_function_id(push_function_id), .push_in0(push_in0), .push_in1(push_in1),
        .cfu(cfu.master),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .busy(busy), .issued_count(issued_count),
        .err_timeout(err_timeout), .err_spurious(err_spurious),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // CFU model: manual mode copies man_* values, auto mode answers with random delays.
    logic        cfu_auto = 1'b0;
    logic        man_cmd_ready = 1'b0, man_rsp_valid = 1'b0;
    logic [31:0] man_rsp_data = '0;
    logic        resp_pending = 1'b0;
    logic [31:0] resp_data = '0;
    int          resp_wait = 0;
    int          hs_count = 0;
    int          proto_errs = 0;
    logic        stall_pending = 1'b0;
    logic [73:0] stall_payload = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] cfu_fn(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
        return a + b + {22'd0, f};
    endfunction

    function automatic logic [73:0] cur_payload();
        return {cfu.cmd_payload_function_id, cfu.cmd_payload_inputs_0, cfu.cmd_payload_inputs_1};
    endfunction

    always @(negedge clk) begin
        if (stall_pending && (cfu.cmd_valid !== 1'b1 || cur_payload() !== stall_payload))
            proto_errs++;
        if (!reset_n) begin
            resp_pending = 1'b0;
            hs_count = 0;
        end
        if (cfu_auto) begin
            cfu.rsp_valid = 1'b0;
            if (resp_pending) begin
                if (resp_wait > 0) resp_wait--;
                else if (cfu.rsp_ready) begin
                    cfu.rsp_valid = 1'b1;
                    cfu.rsp_payload_outputs_0 = resp_data;
                    resp_pending = 1'b0;
                end
            end
            cfu.cmd_ready = ($urandom_range(0, 3) != 0);
        end else begin
            cfu.cmd_ready = man_cmd_ready;
            cfu.rsp_valid = man_rsp_valid;
            cfu.rsp_payload_outputs_0 = man_rsp_data;
        end
        stall_pending = reset_n && cfu.cmd_valid && !cfu.cmd_ready;
        stall_payload = cur_payload();
        if (reset_n && cfu.cmd_valid && cfu.cmd_ready) begin
            hs_count++;
            if (cfu_auto) begin
                resp_pending = 1'b1;
                resp_data = cfu_fn(cfu.cmd_payload_function_id, cfu.cmd_payload_inputs_0,
                                   cfu.cmd_payload_inputs_1);
                resp_wait = $urandom_range(0, 3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!push_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready_wait", push_ready, 1'b1);
        push_function_id = f;
        push_in0 = a;
        push_in1 = b;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        exp_q.push_back(cfu_fn(f, a, b));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            if (pop_valid) begin
                check("pop_data", pop_data, exp_q.pop_front());
                pop_ready = 1'b1;
            end
            tick();
            pop_ready = 1'b0;
            n++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    logic [31:0] r0, r1, rx;
    logic [9:0]  rf;
    logic [73:0] b_payload;

    initial begin
        reset_n = 1'b0;
        push_valid = 1'b0;
        push_function_id = '0;
        push_in0 = '0;
        push_in1 = '0;
        pop_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_valid", cfu.cmd_valid, 1'b0);
        check("rst_rsp_ready", cfu.rsp_ready, 1'b0);
        check("rst_pop_valid", pop_valid, 1'b0);
        check("rst_push_ready", push_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_issued", issued_count, 16'd0);
        check("rst_errs", {err_timeout, err_spurious}, 2'b00);
        check("rst_payload", cur_payload(), 74'd0);
        check("rst_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;
        tick();

        // Single command with exact latencies
        man_cmd_ready = 1'b1;
        push_function_id = 10'h008;
        push_in0 = 32'd5;
        push_in1 = 32'd7;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        check("single_cv_edge0", cfu.cmd_valid, 1'b0);
        check("single_busy", busy, 1'b1);
        tick();
        check("single_cv_edge1", cfu.cmd_valid, 1'b1);
        check("single_payload", cur_payload(), {10'h008, 32'd5, 32'd7});
        tick();
        check("single_rsp_ready", cfu.rsp_ready, 1'b1);
        check("single_cv_drop", cfu.cmd_valid, 1'b0);
        check("single_issued", issued_count, 16'd1);
        man_cmd_ready = 1'b0;
        man_rsp_valid = 1'b1;
        man_rsp_data = 32'd12;
        tick();
        man_rsp_valid = 1'b0;
        check("single_pop_valid", pop_valid, 1'b1);
        check("single_pop_data", pop_data, 32'd12);
        check("single_rsp_ready_drop", cfu.rsp_ready, 1'b0);
        check("single_no_spurious", err_spurious, 1'b0);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        check("single_popped", pop_valid, 1'b0);
        check("single_idle", busy, 1'b0);

        // CFU backpressure: payload held for 10 cycles
        r0 = $urandom;
        r1 = $urandom;
        rf = 10'($urandom_range(0, 1023));
        push_function_id = rf;
        push_in0 = r0;
        push_in1 = r1;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {cfu.cmd_valid, cur_payload()}, {1'b1, rf, r0, r1});
            tick();
        end
        man_cmd_ready = 1'b1;
        tick();
        man_cmd_ready = 1'b0;
        check("bp_issued", issued_count, 16'd2);
        check("bp_wait", dbg_state, ST_WAIT);
        rx = $urandom;
        man_rsp_valid = 1'b1;
        man_rsp_data = rx;
        tick();
        man_rsp_valid = 1'b0;
        check("bp_pop_data", pop_data, rx);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;

        // Credit stall: four results fill the response queue, two commands wait
        cfu_auto = 1'b1;
        for (int k = 1; k <= 6; k++) push_cmd(10'd0, 32'(k), 32'd0);
        repeat (40) tick();
        check("credit_issued", issued_count, 16'd6);
        check("credit_cmd_valid", cfu.cmd_valid, 1'b0);
        check("credit_state", dbg_state, ST_IDLE);
        check("credit_push_ready", push_ready, 1'b1);
        check("credit_busy", busy, 1'b1);
        drain(300);
        check("credit_issued_all", issued_count, 16'd8);

        // Command queue full, simultaneous push and issue-pop
        cfu_auto = 1'b0;
        man_cmd_ready = 1'b0;
        repeat (2) tick();
        push_cmd(10'h011, 32'd100, 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            rf = 10'($urandom_range(0, 1023));
            r0 = $urandom;
            r1 = $urandom;
            if (k == 0) b_payload = {rf, r0, r1};
            push_cmd(rf, r0, r1);
        end
        check("full_push_ready", push_ready, 1'b0);
        rf = 10'h3a5;
        r0 = $urandom;
        r1 = $urandom;
        push_function_id = rf;
        push_in0 = r0;
        push_in1 = r1;
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_hold", push_ready, 1'b0);
        end
        check("full_issued", issued_count, 16'd8);
        man_cmd_ready = 1'b1;
        tick();
        man_cmd_ready = 1'b0;
        man_rsp_valid = 1'b1;
        man_rsp_data = cfu_fn(10'h011, 32'd100, 32'd1);
        tick();
        man_rsp_valid = 1'b0;
        check("full_after_rsp", {dbg_state, push_ready}, {ST_IDLE, 1'b0});
        tick();
        push_valid = 1'b0;
        exp_q.push_back(cfu_fn(rf, r0, r1));
        check("full_swap_ready", push_ready, 1'b0);
        check("full_swap_state", dbg_state, ST_ISSUE);
        check("full_swap_payload", cur_payload(), b_payload);
        cfu_auto = 1'b1;
        drain(400);
        check("full_issued_all", issued_count, 16'd14);

        // Timeout: flag 16 cycles after entering WAIT_RSP, late response still taken
        cfu_auto = 1'b0;
        man_cmd_ready = 1'b1;
        repeat (2) tick();
        push_cmd(10'h2, 32'd40, 32'd2);
        tick();
        tick();
        man_cmd_ready = 1'b0;
        check("to_wait", dbg_state, ST_WAIT);
        repeat (15) tick();
        check("to_before", err_timeout, 1'b0);
        tick();
        check("to_set", err_timeout, 1'b1);
        repeat (3) tick();
        check("to_still_wait", dbg_state, ST_WAIT);
        man_rsp_valid = 1'b1;
        man_rsp_data = cfu_fn(10'h2, 32'd40, 32'd2);
        tick();
        man_rsp_valid = 1'b0;
        check("to_late_idle", dbg_state, ST_IDLE);
        check("to_late_data", {pop_valid, pop_data}, {1'b1, exp_q.pop_front()});
        check("to_sticky", err_timeout, 1'b1);
        check("to_issued", issued_count, 16'd15);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;

        // Spurious response in IDLE
        man_rsp_valid = 1'b1;
        man_rsp_data = 32'hdead_beef;
        tick();
        man_rsp_valid = 1'b0;
        check("sp_flag", err_spurious, 1'b1);
        check("sp_rsp_ready", cfu.rsp_ready, 1'b0);
        tick();
        check("sp_no_capture", pop_valid, 1'b0);

        // Reset mid-ISSUE with both queues occupied
        man_cmd_ready = 1'b1;
        push_cmd(10'h1, 32'd1, 32'd1);
        tick();
        tick();
        man_cmd_ready = 1'b0;
        man_rsp_valid = 1'b1;
        man_rsp_data = 32'h55;
        tick();
        man_rsp_valid = 1'b0;
        push_cmd(10'h2, 32'd2, 32'd2);
        tick();
        push_cmd(10'h3, 32'd3, 32'd3);
        check("prerst_state", {cfu.cmd_valid, dbg_state, pop_valid}, {1'b1, ST_ISSUE, 1'b1});
        reset_n = 1'b0;
        tick();
        check("rst2_cmd_valid", cfu.cmd_valid, 1'b0);
        check("rst2_queues", {pop_valid, push_ready, busy}, 3'b010);
        check("rst2_flags", {err_timeout, err_spurious}, 2'b00);
        check("rst2_issued", issued_count, 16'd0);
        reset_n = 1'b1;
        exp_q.delete();
        tick();

        // Randomized traffic against the queue model
        cfu_auto = 1'b1;
        for (int c = 0; c < 800; c++) begin
            push_valid = push_ready && ($urandom_range(0, 2) != 0);
            push_function_id = 10'($urandom_range(0, 1023));
            push_in0 = $urandom;
            push_in1 = $urandom;
            if (push_valid) exp_q.push_back(cfu_fn(push_function_id, push_in0, push_in1));
            pop_ready = ($urandom_range(0, 2) != 0);
            if (pop_valid && pop_ready) begin
                check("rand_pop_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("rand_pop_data", pop_data, exp_q.pop_front());
            end
            tick();
        end
        push_valid = 1'b0;
        pop_ready = 1'b0;
        drain(500);
        repeat (4) tick();
        check("rand_issued", issued_count, 16'(hs_count));
        check("rand_busy", busy, 1'b0);
        check("rand_flags", {err_timeout, err_spurious}, 2'b00);
        check("cmd_stable_protocol", proto_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
